// File: rtl/topk_pkg.sv
// Shared types and helpers for the top-k result collector.
package topk_pkg;

    localparam int unsigned K_MAX_DEFAULT = 8;
    localparam int unsigned CNT_W         = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_READY   = 2'd2,
        ST_DRAIN   = 2'd3
    } state_e;

    // k of zero or beyond the buffer depth means "fill the whole buffer".
    function automatic logic [CNT_W-1:0] k_eff_f(input logic [15:0] k, input int unsigned k_max);
        if (k == 16'd0 || 32'(k) > k_max) begin
            return CNT_W'(k_max);
        end
        return CNT_W'(k);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one history register, pulse is high for the cycle the level first reads high.
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic level_i,
    output logic pulse_c_o
);

    logic level_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_c_o = level_i & ~level_q;

endmodule

// File: rtl/topk_collector.sv
// Collects k results per query into a small buffer and lets the host pop them one per request edge.
// Define TOPK_SORT_EN to keep the buffer ascending by unsigned value (stable insert); otherwise arrival order.
module topk_collector
    import topk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned K_MAX      = K_MAX_DEFAULT
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic                  result_valid_in,
    input  logic [15:0]           k_in,
    input  logic                  host_req_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid_out,
    output logic [CNT_W-1:0]      count_out,
    output logic                  done_out,
    output logic                  overflow_out
);

    localparam int unsigned PTR_W = (K_MAX > 1) ? $clog2(K_MAX) : 1;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      keff_q, keff_d;
    logic [PTR_W-1:0]      rd_q, rd_d;
    logic                  ovf_q, ovf_d;
    logic                  valid_q;
    logic                  ready_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] mem_q [K_MAX];
    logic [DATA_WIDTH-1:0] mem_d [K_MAX];
    logic                  pop_c;

    rise_detect u_rise (
        .clk_i     (clk_in),
        .rst_i     (rst_in),
        .level_i   (host_req_in),
        .pulse_c_o (pop_c)
    );

`ifdef TOPK_SORT_EN
    // Insert slot is the first held entry strictly greater than the new value, so ties keep arrival order.
    logic [CNT_W-1:0] ins_pos_c;
    always_comb begin
        ins_pos_c = count_q;
        for (int i = int'(K_MAX) - 1; i >= 0; i--) begin
            if (CNT_W'(i) < count_q && result_in < mem_q[i]) begin
                ins_pos_c = CNT_W'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        keff_d  = keff_q;
        rd_d    = rd_q;
        ovf_d   = ovf_q;
        mem_d   = mem_q;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (result_valid_in) begin
                    if (state_q == ST_IDLE) begin
                        keff_d = k_eff_f(k_in, K_MAX);
                    end
`ifdef TOPK_SORT_EN
                    for (int i = 1; i < int'(K_MAX); i++) begin
                        if (CNT_W'(i) > ins_pos_c && CNT_W'(i) <= count_q) begin
                            mem_d[i] = mem_q[i-1];
                        end
                    end
                    mem_d[ins_pos_c[PTR_W-1:0]] = result_in;
`else
                    mem_d[count_q[PTR_W-1:0]] = result_in;
`endif
                    count_d = count_q + CNT_W'(1);
                    state_d = (count_d == keff_d) ? ST_READY : ST_COLLECT;
                end
            end
            ST_READY, ST_DRAIN: begin
                if (result_valid_in) begin
                    ovf_d = 1'b1;
                end
                if (pop_c) begin
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        count_d = '0;
                        rd_d    = '0;
                    end else begin
                        state_d = ST_DRAIN;
                        count_d = count_q - CNT_W'(1);
                        rd_d    = rd_q + PTR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_READY) || (state_d == ST_DRAIN);
    end

    // Outputs are registered from next-state values so they line up with count/state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            keff_q  <= '0;
            rd_q    <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            keff_q  <= keff_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
            valid_q <= ready_d;
            data_q  <= ready_d ? mem_d[rd_d] : '0;
        end
        mem_q <= mem_d;
    end

    assign data_out       = data_q;
    assign data_valid_out = valid_q;
    assign done_out       = valid_q;
    assign count_out      = count_q;
    assign overflow_out   = ovf_q;

endmodule

// File: tb/tb_topk_collector.sv
// Bench for topk_collector: directed table, corner sequences and random traffic against a queue model.
module tb_topk_collector;

    localparam int unsigned DW = 32;
    localparam int unsigned KM = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rv;
    logic          hr;
    logic [DW-1:0] rdat;
    logic [15:0]   kk_in;
    logic [DW-1:0] dout;
    logic          dv;
    logic          done;
    logic          ovf;
    logic [6:0]    cnt;

    always #5 clk = ~clk;

    topk_collector #(.DATA_WIDTH(DW), .K_MAX(KM)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .result_in       (rdat),
        .result_valid_in (rv),
        .k_in            (kk_in),
        .host_req_in     (hr),
        .data_out        (dout),
        .data_valid_out  (dv),
        .count_out       (cnt),
        .done_out        (done),
        .overflow_out    (ovf)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference: held entries as a queue, a ready flag and a sticky overflow.
    int unsigned mq[$];
    bit          m_ready;
    bit          m_ovf;
    bit          m_hprev;
    int unsigned m_k;

    task automatic model_step(input bit r, input bit v, input int unsigned d,
                              input int unsigned k, input bit h);
        bit pop;
        int idx;
        if (r) begin
            mq.delete();
            m_ready = 1'b0;
            m_ovf   = 1'b0;
            m_hprev = 1'b0;
            return;
        end
        pop     = h && !m_hprev;
        m_hprev = h;
        if (!m_ready) begin
            if (v) begin
                if (mq.size() == 0) m_k = (k == 0 || k > KM) ? KM : k;
`ifdef TOPK_SORT_EN
                idx = 0;
                foreach (mq[i]) if (mq[i] <= d) idx = i + 1;
                mq.insert(idx, d);
`else
                idx = mq.size();
                mq.insert(idx, d);
`endif
                if (mq.size() == m_k) m_ready = 1'b1;
            end
        end else begin
            if (v) m_ovf = 1'b1;
            if (pop) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_ready = 1'b0;
            end
        end
    endtask

    task automatic apply(input bit r, input bit v, input logic [31:0] d,
                         input logic [15:0] k, input bit h);
        rst   = r;
        rv    = v;
        rdat  = d;
        kk_in = k;
        hr    = h;
        model_step(r, v, d, 32'(k), h);
        @(posedge clk);
        #1;
    endtask

    function automatic void check(input string nm, input logic [31:0] ed, input bit ev,
                                  input logic [6:0] ec, input bit eo);
        n_vec++;
        if (dout !== ed || dv !== ev || done !== ev || cnt !== ec || ovf !== eo) begin
            n_err++;
            $display("FAIL %s: got data=%0d valid=%0b done=%0b count=%0d ovf=%0b, want data=%0d valid=%0b done=%0b count=%0d ovf=%0b",
                     nm, dout, dv, done, cnt, ovf, ed, ev, ev, ec, eo);
        end
    endfunction

    function automatic void check_model(input string nm);
        logic [31:0] ed;
        ed = m_ready ? mq[0] : 32'd0;
        check(nm, ed, m_ready, 7'(mq.size()), m_ovf);
    endfunction

    typedef struct {
        bit          v;
        logic [31:0] d;
        bit          h;
        logic [31:0] ed;
        bit          ev;
        logic [6:0]  ec;
        bit          eo;
    } vec_t;

    function automatic vec_t mk(input bit v, input logic [31:0] d, input bit h,
                                input logic [31:0] ed, input bit ev, input logic [6:0] ec, input bit eo);
        vec_t t;
        t.v = v; t.d = d; t.h = h; t.ed = ed; t.ev = ev; t.ec = ec; t.eo = eo;
        return t;
    endfunction

    vec_t        tbl[11];
    logic [31:0] e[4];
    bit          hlev;

    initial begin
`ifdef TOPK_SORT_EN
        e[0] = 32'd1; e[1] = 32'd1; e[2] = 32'd5; e[3] = 32'd7;
`else
        e[0] = 32'd5; e[1] = 32'd7; e[2] = 32'd1; e[3] = 32'd1;
`endif
        // k=4, results 5,7,1,1, then pops with a drop and a pop/drop collision in DRAIN.
        tbl[0]  = mk(1'b1, 32'd5,  1'b0, 32'd0, 1'b0, 7'd1, 1'b0);
        tbl[1]  = mk(1'b1, 32'd7,  1'b0, 32'd0, 1'b0, 7'd2, 1'b0);
        tbl[2]  = mk(1'b1, 32'd1,  1'b0, 32'd0, 1'b0, 7'd3, 1'b0);
        tbl[3]  = mk(1'b1, 32'd1,  1'b0, e[0],  1'b1, 7'd4, 1'b0);
        tbl[4]  = mk(1'b0, 32'd0,  1'b1, e[1],  1'b1, 7'd3, 1'b0);
        tbl[5]  = mk(1'b0, 32'd0,  1'b0, e[1],  1'b1, 7'd3, 1'b0);
        tbl[6]  = mk(1'b0, 32'd0,  1'b1, e[2],  1'b1, 7'd2, 1'b0);
        tbl[7]  = mk(1'b1, 32'd99, 1'b0, e[2],  1'b1, 7'd2, 1'b1);
        tbl[8]  = mk(1'b1, 32'd3,  1'b1, e[3],  1'b1, 7'd1, 1'b1);
        tbl[9]  = mk(1'b0, 32'd0,  1'b0, e[3],  1'b1, 7'd1, 1'b1);
        tbl[10] = mk(1'b0, 32'd0,  1'b1, 32'd0, 1'b0, 7'd0, 1'b1);

        apply(1'b1, 1'b0, 32'd0, 16'd0, 1'b0);
        apply(1'b1, 1'b0, 32'd0, 16'd0, 1'b0);
        check("reset", 32'd0, 1'b0, 7'd0, 1'b0);

        foreach (tbl[i]) begin
            apply(1'b0, tbl[i].v, tbl[i].d, 16'd4, tbl[i].h);
            check($sformatf("tbl%0d", i), tbl[i].ed, tbl[i].ev, tbl[i].ec, tbl[i].eo);
        end

        // k=0 clamps to K_MAX; the ninth and tenth results are dropped.
        apply(1'b1, 1'b0, 32'd0, 16'd0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 32'(100 + i), 16'd0, 1'b0);
            if (i == 7) check("clamp_full", 32'd100, 1'b1, 7'd8, 1'b0);
        end
        check("clamp_ovf", 32'd100, 1'b1, 7'd8, 1'b1);

        // Host edges during COLLECT are ignored and not queued.
        apply(1'b1, 1'b0, 32'd0, 16'd0, 1'b0);
        apply(1'b0, 1'b1, 32'd100, 16'd3, 1'b0);
        apply(1'b0, 1'b1, 32'd200, 16'd3, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd3, 1'b1);
        check("collect_edge1", 32'd0, 1'b0, 7'd2, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd3, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd3, 1'b1);
        check("collect_edge2", 32'd0, 1'b0, 7'd2, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd3, 1'b0);
        apply(1'b0, 1'b1, 32'd50, 16'd3, 1'b0);
`ifdef TOPK_SORT_EN
        check("collect_ready", 32'd50, 1'b1, 7'd3, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd3, 1'b1);
        check("collect_pop1", 32'd100, 1'b1, 7'd2, 1'b0);
`else
        check("collect_ready", 32'd100, 1'b1, 7'd3, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd3, 1'b1);
        check("collect_pop1", 32'd200, 1'b1, 7'd2, 1'b0);
`endif

        // Reset mid-collect with host held high: nothing pops after release, next query works.
        apply(1'b1, 1'b0, 32'd0, 16'd0, 1'b0);
        apply(1'b0, 1'b1, 32'd10, 16'd4, 1'b0);
        apply(1'b0, 1'b1, 32'd20, 16'd4, 1'b1);
        apply(1'b1, 1'b0, 32'd0, 16'd4, 1'b1);
        check("rst_mid", 32'd0, 1'b0, 7'd0, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd2, 1'b1);
        check("rst_release", 32'd0, 1'b0, 7'd0, 1'b0);
        apply(1'b0, 1'b1, 32'd30, 16'd2, 1'b1);
        check("rst_q1", 32'd0, 1'b0, 7'd1, 1'b0);
        apply(1'b0, 1'b1, 32'd40, 16'd2, 1'b1);
        check("rst_q2", 32'd30, 1'b1, 7'd2, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd2, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd2, 1'b1);
        check("rst_pop1", 32'd40, 1'b1, 7'd1, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd2, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 16'd2, 1'b1);
        check("rst_pop2", 32'd0, 1'b0, 7'd0, 1'b0);

        // Random traffic against the queue model; small value range forces ties.
        apply(1'b1, 1'b0, 32'd0, 16'd0, 1'b0);
        hlev = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) hlev = ~hlev;
            apply(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 15)), 16'($urandom_range(0, 10)), hlev);
            check_model($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/topk_collector.md
TOPK_COLLECTOR -- requirements
Module: topk_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the result word width.
REQ-002 SHALL have parameter K_MAX, default 8, meaning the result buffer depth; legal range is 1..64.
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port result_in, input, DATA_WIDTH bits: result word from the upstream search stage.
REQ-006 SHALL have port result_valid_in, input, 1 bit: result_in is valid this cycle; there is no backpressure.
REQ-007 SHALL have port k_in, input, 16 bits: number of results expected per query.
REQ-008 SHALL have port host_req_in, input, 1 bit: level from the debug register; each rising edge requests one pop.
REQ-009 SHALL have port data_out, output, DATA_WIDTH bits: entry at the read pointer.
REQ-010 SHALL have port data_valid_out, output, 1 bit: data_out holds an unread result.
REQ-011 SHALL have port count_out, output, 7 bits: number of entries currently held.
REQ-012 SHALL have port done_out, output, 1 bit: all k results have been captured.
REQ-013 SHALL have port overflow_out, output, 1 bit: sticky flag set when a result is dropped.

Function
REQ-014 SHALL implement the states IDLE, COLLECT, READY and DRAIN.
REQ-015 IDLE: when result_valid_in is high, SHALL latch k_eff, store the result at index 0, set count to 1, and go to COLLECT; if k_eff=1, SHALL go directly to READY.
REQ-016 k_eff SHALL equal k_in, except that k_in=0 or k_in>K_MAX SHALL clamp to K_MAX.
REQ-017 COLLECT: each result_valid_in SHALL store the result at index count and increment count; on reaching k_eff, SHALL go to READY the next cycle.
REQ-018 A captured result SHALL be reflected in count_out on the cycle after capture.
REQ-019 READY/DRAIN: SHALL assert data_valid_out and done_out, and data_out SHALL show the entry at the read pointer (starting at 0).
REQ-020 A host_req_in rising edge SHALL be detected with one register, and the pop SHALL take effect on the cycle after the edge.
REQ-021 Each pop SHALL advance the read pointer and decrement count; the first pop SHALL move READY to DRAIN.
REQ-022 The pop of the last entry SHALL return the block to IDLE, with count 0 and both pointers 0.
REQ-023 host_req_in edges in IDLE or COLLECT SHALL be ignored and SHALL NOT be queued.
REQ-024 A result_valid_in in READY or DRAIN SHALL be dropped and SHALL set overflow_out.
REQ-025 overflow_out SHALL clear only on reset.
REQ-026 A pop and an arriving result in the same cycle in DRAIN SHALL perform the pop, drop the result, and set overflow.
REQ-027 host_req_in SHALL be treated as same-clock-domain, with no synchronizer.

Reset
REQ-028 rst_in SHALL force IDLE, clear all pointers and count, clear done_out, data_valid_out and overflow_out, and drive data_out to 0.
REQ-029 Reset SHALL also reset the edge-detect register to 0, so a high host_req_in at reset release SHALL NOT cause a pop.
REQ-030 Reset asserted mid-COLLECT or mid-DRAIN SHALL discard all stored entries; buffer contents need not be cleared.

Configuration
REQ-031 With macro TOPK_SORT_EN defined, each capture SHALL insert the result into the buffer so it stays ascending by unsigned value, with a single-cycle shift insert and equal values kept in arrival order.
REQ-032 With TOPK_SORT_EN defined, the pop order SHALL be ascending.
REQ-033 Without TOPK_SORT_EN, entries SHALL be stored and popped in arrival order and no compare logic SHALL be synthesized.

Structure
REQ-034 Package topk_pkg SHALL hold the state enum, the default K_MAX constant, and the k_eff clamp function.
REQ-035 Sub-module rise_detect SHALL provide a registered rising-edge pulse for host_req_in.

Verification
REQ-036 k_in=4, results 5,7,1,1 on consecutive cycles -> done_out=1, count_out=4; four host edges pop 5,7,1,1 (sorted build: 1,1,5,7); then IDLE with data_valid_out=0.
REQ-037 k_in=0, K_MAX=8, ten results -> 8 captured, done_out=1, overflow_out=1, count_out=8.
REQ-038 Host edges during COLLECT (k_in=3, 2 results in) -> count_out stays 2; after the third result, the first pop returns the first result.
REQ-039 In DRAIN, a pop edge coincident with result_valid_in=1 -> count decrements by 1, overflow_out=1, and the dropped value never appears.
REQ-040 Reset asserted with host_req_in held high, after 2 of 4 results -> all outputs 0, no pop after release; a new query of k=2 completes normally.
